// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Frame sequencer for a UART transmitter. Produces the select for an
//   external output mux (start / stop-idle / data / parity), the current
//   payload bit and the frame parity bit. One frame bit is sent per CLK cycle.
//
// Ports
//   CLK        in   bit-rate clock
//   RST        in   asynchronous reset, active-low
//   P_DATA     in   parallel payload (DATA_WIDTH bits)
//   DATA_VALID in   payload-valid strobe; accepted in IDLE or STOP only
//   PAR_EN     in   1 = insert parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   mux_sel    out  00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data   out  current payload bit, LSB first
//   par_bit    out  parity of the latched payload
//   busy       out  high while a frame is in progress
//
// The downstream mux registers its output; that one-cycle lag is left to the
// mux, so mux_sel and ser_data here are aligned to each other.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q,   shreg_d;
    logic                    par_en_q,  par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic [1:0]              mux_sel_q, mux_sel_d;
    logic                    busy_q,    busy_d;
    logic                    accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

        case (state_q)
            IDLE: begin
                if (DATA_VALID) state_d = START;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    // LSB of the shift register is always the bit on the line
                    shreg_d = shreg_q >> 1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = DATA_VALID ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Parity is computed once from the unshifted payload so it stays
        // stable for the whole frame while the shift register drains.
        if (accept) begin
            shreg_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
            cnt_d     = '0;
        end

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register (Moore, glitch-free).
        case (state_d)
            START:   begin mux_sel_d = 2'b00; busy_d = 1'b1; end
            DATA:    begin mux_sel_d = 2'b10; busy_d = 1'b1; end
            PARITY:  begin mux_sel_d = 2'b11; busy_d = 1'b1; end
            STOP:    begin mux_sel_d = 2'b01; busy_d = 1'b1; end
            default: begin mux_sel_d = 2'b01; busy_d = 1'b0; end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            mux_sel_q <= 2'b01;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
        end
    end

    assign mux_sel  = mux_sel_q;
    assign busy     = busy_q;
    assign ser_data = shreg_q[0];
    assign par_bit  = par_bit_q;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, serial payload bits per frame.
REQ-002 SHALL provide CLK  input  1  bit-rate clock; one frame bit per CLK cycle.
REQ-003 SHALL provide RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide P_DATA  input  DATA_WIDTH  parallel payload.
REQ-005 SHALL provide DATA_VALID  input  1  payload-valid strobe, one cycle.
REQ-006 SHALL provide PAR_EN  input  1  1 = parity bit inserted.
REQ-007 SHALL provide PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL provide mux_sel  output  2  output-mux select: 00 start, 01 stop/idle, 10 data, 11 parity.
REQ-009 SHALL provide ser_data  output  1  current payload bit, for mux data input.
REQ-010 SHALL provide par_bit  output  1  computed parity, for mux parity input.
REQ-011 SHALL provide busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL hold each of START, PARITY, STOP for exactly one CLK cycle.
REQ-014 SHALL hold DATA for exactly DATA_WIDTH cycles, tracked by a bit counter 0..DATA_WIDTH-1.
REQ-015 SHALL decode mux_sel from state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-016 SHALL assert busy in START, DATA, PARITY, STOP; deassert in IDLE.
REQ-017 SHALL accept a frame when DATA_VALID=1 in IDLE or STOP, and transition to START next cycle.
REQ-018 SHALL latch P_DATA, PAR_EN, PAR_TYP on acceptance; later input changes SHALL NOT affect the frame.
REQ-019 SHALL ignore DATA_VALID in START, DATA, PARITY; no queueing, no error flag.
REQ-020 SHALL shift the latched payload LSB first; ser_data = current bit, valid throughout DATA.
REQ-021 SHALL advance one payload bit per CLK cycle in DATA, and leave DATA after counter = DATA_WIDTH-1.
REQ-022 SHALL transition DATA -> PARITY if latched PAR_EN=1, otherwise DATA -> STOP.
REQ-023 SHALL set par_bit = XOR of latched payload for even and its inverse for odd.
REQ-024 SHALL hold par_bit stable from START through STOP.
REQ-025 SHALL transition STOP -> IDLE when no acceptance occurs; STOP -> START on acceptance (back-to-back).
REQ-026 SHALL produce frame length 1+DATA_WIDTH+1, plus 1 if parity is enabled, in CLK cycles.
REQ-027 Downstream output mux registers its output, so line bits lag mux_sel by one CLK.
REQ-028 SHALL keep this controller free of that lag compensation; mux_sel and ser_data are aligned to each other.

Reset
REQ-029 SHALL on RST=0 immediately force state IDLE, counter 0, payload register 0, latched PAR_EN/PAR_TYP 0.
REQ-030 SHALL drive reset output values mux_sel=01, busy=0, ser_data=0, par_bit=0.
REQ-031 SHALL abort any in-progress frame on reset with no resumption; first accepted frame after release starts cleanly.

Verification
REQ-032 SHALL verify P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> mux_sel 00, then 10 x8 with ser_data 1,0,1,0,0,1,0,1, then 11 with par_bit=0, then 01; busy high for 11 cycles.
REQ-033 SHALL verify P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> par_bit=0; with PAR_TYP=0 -> par_bit=1.
REQ-034 SHALL verify PAR_EN=0, P_DATA=8'hFF -> mux_sel never 11, frame 10 cycles, busy high 10 cycles.
REQ-035 SHALL verify DATA_VALID pulsed in STOP with P_DATA=8'h3C -> next cycle START, busy stays high continuously, second frame correct.
REQ-036 SHALL verify DATA_VALID with P_DATA=8'h00 pulsed mid-DATA of an 8'hA5 frame -> ignored, 8'hA5 frame unaltered, return to IDLE.
REQ-037 SHALL verify RST asserted at DATA bit 3 -> same-cycle mux_sel=01, busy=0; after release with DATA_VALID 8'h5A -> full correct frame.
